// File: rtl/load_extract_unit.sv
// load_extract_unit: MEM-stage load path. Issues one word read to a
// variable-latency data memory, stalls the pipeline until the data returns,
// then extracts, aligns and sign/zero-extends LB/LBU/LH/LHU/LW (little endian).
// Optional macro UNALIGNED_LOAD_EN adds LWL (type 5) and LWR (type 6).
module load_extract_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] rt_old,
    input  logic        flush,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        stall,
    output logic        load_done,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       type_q;
    logic [1:0]       k_q;
    logic [31:0]      rt_q;

    logic             aligned;
    logic             accept;
    logic             timeout;
    logic             rd_en_d;
    logic             addr_err_d;
    logic             bus_err_d;
    logic             capture;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      extract;

`ifndef UNALIGNED_LOAD_EN
    logic             unused_rt;
    assign unused_rt = ^rt_q;
`endif

    // Alignment check of the incoming request; undefined types count as misaligned
    always_comb begin
        aligned = 1'b0;
        case (load_type)
            3'd0, 3'd1: aligned = 1'b1;
            3'd2, 3'd3: aligned = ~addr[0];
            3'd4:       aligned = (addr[1:0] == 2'b00);
`ifdef UNALIGNED_LOAD_EN
            3'd5, 3'd6: aligned = 1'b1;
`endif
            default:    aligned = 1'b0;
        endcase
    end

    assign accept  = (state_q == IDLE) && load_req && !flush && aligned;
    // >= so that a flush on the last WAIT cycle still drains out in DRAIN
    assign timeout = (cnt_q >= CNT_LAST);
    assign stall   = accept || (state_q == WAIT) || (state_q == DRAIN);

    // Next-state and registered-pulse decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req && !flush) begin
                    if (aligned) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        rd_en_d = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = mem_rd_valid ? IDLE : DRAIN;
                end else if (mem_rd_valid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (timeout) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rd_valid || timeout) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte/halfword lane selection and extension from the latched offset and type
    assign byte_sel = mem_rd_data[{k_q, 3'b000} +: 8];
    assign half_sel = k_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    // Writeback value formation
    always_comb begin
        extract = mem_rd_data;
        case (type_q)
            3'd0: extract = {{24{byte_sel[7]}}, byte_sel};
            3'd1: extract = {24'h000000, byte_sel};
            3'd2: extract = {{16{half_sel[15]}}, half_sel};
            3'd3: extract = {16'h0000, half_sel};
            3'd4: extract = mem_rd_data;
`ifdef UNALIGNED_LOAD_EN
            3'd5: begin
                case (k_q)
                    2'd0:    extract = {mem_rd_data[7:0],  rt_q[23:0]};
                    2'd1:    extract = {mem_rd_data[15:0], rt_q[15:0]};
                    2'd2:    extract = {mem_rd_data[23:0], rt_q[7:0]};
                    default: extract = mem_rd_data;
                endcase
            end
            3'd6: begin
                case (k_q)
                    2'd0:    extract = mem_rd_data;
                    2'd1:    extract = {rt_q[31:24], mem_rd_data[31:8]};
                    2'd2:    extract = {rt_q[31:16], mem_rd_data[31:16]};
                    default: extract = {rt_q[31:8],  mem_rd_data[31:24]};
                endcase
            end
`endif
            default: extract = mem_rd_data;
        endcase
    end

    // FSM state, timeout counter and one-cycle control pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_rd_en <= 1'b0;
            load_done <= 1'b0;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_rd_en <= rd_en_d;
            load_done <= (state_d == DONE);
            addr_err  <= addr_err_d;
            bus_err   <= bus_err_d;
        end
    end

    // Request latching on accept and writeback capture on valid read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            type_q    <= '0;
            k_q       <= '0;
            rt_q      <= '0;
            mem_addr  <= '0;
            load_data <= '0;
        end else begin
            if (accept) begin
                type_q   <= load_type;
                k_q      <= addr[1:0];
                rt_q     <= rt_old;
                mem_addr <= {addr[31:2], 2'b00};
            end
            if (capture) begin
                load_data <= extract;
            end
        end
    end

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed bench for load_extract_unit. Each load runs a fixed window of
// cycles; cycle 0 is the request cycle and the memory model returns data
// in cycle 1+lat. Outputs are sampled shortly after the falling edge.
module tb_load_extract_unit;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic        flush;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        stall;
    logic        load_done;
    logic [31:0] load_data;
    logic        addr_err;
    logic        bus_err;

    int n_checks;
    int n_fail;

    int          r_rd;
    int          r_done;
    int          r_aerr;
    int          r_berr;
    int          r_stall;
    int          r_evt;
    logic [31:0] r_addr;

    load_extract_unit #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_req(load_req),
        .load_type(load_type),
        .addr(addr),
        .rt_old(rt_old),
        .flush(flush),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .stall(stall),
        .load_done(load_done),
        .load_data(load_data),
        .addr_err(addr_err),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat < 0: memory never answers. flush_at < 0: no flush.
    task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rt,
                            input logic [31:0] d, input int lat, input int flush_at);
        r_rd = 0; r_done = 0; r_aerr = 0; r_berr = 0; r_stall = 0; r_evt = 0;
        r_addr = '0;
        load_type = t;
        addr      = a;
        rt_old    = rt;
        load_req  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            mem_rd_valid = (lat >= 0) && (c == 1 + lat);
            mem_rd_data  = mem_rd_valid ? d : 32'h5A5A_5A5A;
            flush        = (flush_at >= 0) && (c == flush_at);
            if (flush) load_req = 1'b0;
            #1;
            if (mem_rd_en) begin r_rd++; r_addr = mem_addr; end
            if (load_done) begin r_done++; r_evt = c; end
            if (addr_err)  begin r_aerr++; r_evt = c; end
            if (bus_err)   begin r_berr++; r_evt = c; end
            if (load_done || addr_err || bus_err) load_req = 1'b0;
            #1;
            if (stall) r_stall++;
            @(negedge clk);
        end
        mem_rd_valid = 1'b0;
        flush        = 1'b0;
        load_req     = 1'b0;
    endtask

    task automatic check_load(input string tag, input int e_rd, input logic [31:0] e_addr,
                              input int e_done, input int e_evt, input logic [31:0] e_data,
                              input int e_aerr, input int e_berr, input int e_stall);
        check({tag, ".rd_en_count"}, r_rd, e_rd);
        check({tag, ".mem_addr"}, r_addr, e_addr);
        check({tag, ".done_count"}, r_done, e_done);
        check({tag, ".event_cycle"}, r_evt, e_evt);
        check({tag, ".load_data"}, load_data, e_data);
        check({tag, ".addr_err_count"}, r_aerr, e_aerr);
        check({tag, ".bus_err_count"}, r_berr, e_berr);
        check({tag, ".stall_cycles"}, r_stall, e_stall);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        load_req     = 1'b0;
        load_type    = 3'd0;
        addr         = '0;
        rt_old       = '0;
        flush        = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("reset.load_done", {31'd0, load_done}, 32'd0);
        check("reset.addr_err", {31'd0, addr_err}, 32'd0);
        check("reset.bus_err", {31'd0, bus_err}, 32'd0);
        check("reset.stall", {31'd0, stall}, 32'd0);
        check("reset.load_data", load_data, 32'h0000_0000);
        check("reset.mem_addr", mem_addr, 32'h0000_0000);
        @(negedge clk);

        // LB 0x103: byte 3 = 0x80, sign-extended
        run_load(3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0011, 2, -1);
        check_load("lb_103", 1, 32'h0000_0100, 1, 4, 32'hFFFF_FF80, 0, 0, 4);

        // LHU/LH 0x202 at minimum latency: upper half 0x8001
        run_load(3'd3, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, -1);
        check_load("lhu_202", 1, 32'h0000_0200, 1, 2, 32'h0000_8001, 0, 0, 2);
        run_load(3'd2, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, -1);
        check_load("lh_202", 1, 32'h0000_0200, 1, 2, 32'hFFFF_8001, 0, 0, 2);

        // LBU 0x101: byte 1 = 0x80, zero-extended
        run_load(3'd1, 32'h0000_0101, 32'h0, 32'h1234_80FF, 1, -1);
        check_load("lbu_101", 1, 32'h0000_0100, 1, 3, 32'h0000_0080, 0, 0, 3);

        // Misaligned and undefined types: addr_err in cycle 1, no access
        run_load(3'd4, 32'h0000_0105, 32'h0, 32'h1111_1111, 1, -1);
        check_load("lw_105_mis", 0, 32'h0, 0, 1, 32'h0000_0080, 1, 0, 0);
        run_load(3'd2, 32'h0000_0203, 32'h0, 32'h1111_1111, 1, -1);
        check_load("lh_203_mis", 0, 32'h0, 0, 1, 32'h0000_0080, 1, 0, 0);
        run_load(3'd7, 32'h0000_0200, 32'h0, 32'h1111_1111, 1, -1);
        check_load("type7_undef", 0, 32'h0, 0, 1, 32'h0000_0080, 1, 0, 0);

        // Timeout: 16 WAIT cycles, bus_err in cycle 17
        run_load(3'd4, 32'h0000_0300, 32'h0, 32'h0, -1, -1);
        check_load("lw_300_timeout", 1, 32'h0000_0300, 0, 17, 32'h0000_0080, 0, 1, 17);

        // Flush in WAIT (cycle 2), data arrives in cycle 5 and is discarded
        run_load(3'd4, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 4, 2);
        check_load("lw_400_flush", 1, 32'h0000_0400, 0, 0, 32'h0000_0080, 0, 0, 6);
        run_load(3'd0, 32'h0000_0401, 32'h0, 32'h0000_7F00, 1, -1);
        check_load("lb_401_after_flush", 1, 32'h0000_0400, 1, 3, 32'h0000_007F, 0, 0, 3);

        // Flush and valid in the same cycle: flush wins
        run_load(3'd4, 32'h0000_0500, 32'h0, 32'h1111_1111, 2, 3);
        check_load("lw_500_flush_valid", 1, 32'h0000_0500, 0, 0, 32'h0000_007F, 0, 0, 4);

        run_load(3'd4, 32'h0000_0504, 32'h0, 32'hCAFE_F00D, 5, -1);
        check_load("lw_504", 1, 32'h0000_0504, 1, 7, 32'hCAFE_F00D, 0, 0, 7);

`ifdef UNALIGNED_LOAD_EN
        run_load(3'd5, 32'h0000_0601, 32'h1122_3344, 32'hAABB_CCDD, 1, -1);
        check_load("lwl_601", 1, 32'h0000_0600, 1, 3, 32'hCCDD_3344, 0, 0, 3);
        run_load(3'd6, 32'h0000_0601, 32'h1122_3344, 32'hAABB_CCDD, 1, -1);
        check_load("lwr_601", 1, 32'h0000_0600, 1, 3, 32'h11AA_BBCC, 0, 0, 3);
`else
        run_load(3'd5, 32'h0000_0600, 32'h1122_3344, 32'hAABB_CCDD, 1, -1);
        check_load("type5_undef", 0, 32'h0, 0, 1, 32'hCAFE_F00D, 1, 0, 0);
        run_load(3'd6, 32'h0000_0600, 32'h1122_3344, 32'hAABB_CCDD, 1, -1);
        check_load("type6_undef", 0, 32'h0, 0, 1, 32'hCAFE_F00D, 1, 0, 0);
`endif

        // Stray valid while idle is ignored
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        #1;
        check("idle_valid.load_done", {31'd0, load_done}, 32'd0);
        check("idle_valid.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // Reset in WAIT: no late load_done, registers cleared
        load_type = 3'd4;
        addr      = 32'h0000_0700;
        load_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r_done = 0;
        for (int c = 0; c < 6; c++) begin
            mem_rd_valid = (c == 0);
            mem_rd_data  = 32'h7777_7777;
            #1;
            if (load_done) r_done++;
            if (c == 0) check("midreset.stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
        end
        mem_rd_valid = 1'b0;
        check("midreset.done_count", r_done, 0);
        check("midreset.load_data", load_data, 32'h0000_0000);
        check("midreset.mem_addr", mem_addr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
